// File: rtl/serial_reg_bridge_pkg.sv
// Shared state encoding, status codes and parameter defaults for the serial register bridge.
package serial_reg_bridge_pkg;

    localparam int DATA_W_DEF      = 32;
    localparam int ADDR_W_DEF      = 16;
    localparam int TO_CYC_DEF      = 255;
    localparam int SYNC_STAGES_DEF = 2;

    // Wide enough for the longest shift sequence (2 status + 64 data + 1 parity).
    localparam int CNT_W = 7;

    localparam logic [1:0] ST_ACK  = 2'b00;
    localparam logic [1:0] ST_NACK = 2'b01;
    localparam logic [1:0] ST_UNK  = 2'b10;
    localparam logic [1:0] ST_TO   = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_HDR   = 3'd1,
        S_WDATA = 3'd2,
        S_REQ   = 3'd3,
        S_WAIT  = 3'd4,
        S_LOAD  = 3'd5,
        S_SHOUT = 3'd6,
        S_DONE  = 3'd7
    } srb_state_e;

endpackage

// File: rtl/serial_reg_bridge_if.sv
// Register-bus side of the bridge: request, address/data and slave response lines.
interface serial_reg_bridge_if
    import serial_reg_bridge_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) ();

    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic [DATA_W-1:0] rdata;
    logic              wr;
    logic              rd;
    logic              ack;
    logic              nack;
    logic              unknown;

    modport master (
        output addr, data, wr, rd,
        input  rdata, ack, nack, unknown
    );

    modport slave (
        input  addr, data, wr, rd,
        output rdata, ack, nack, unknown
    );

endinterface

// File: rtl/srb_edge_sync.sv
// Synchronises SDa/SCl into clk and derives SCl edge strobes plus start/stop conditions.
module srb_edge_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sda_i,
    input  logic scl_i,
    output logic sda_o,
    output logic scl_rise_o,
    output logic scl_fall_o,
    output logic start_o,
    output logic stop_o
);

    logic [STAGES-1:0] sda_sync_q;
    logic [STAGES-1:0] scl_sync_q;
    logic              sda_prev_q;
    logic              scl_prev_q;
    logic              sda_s;
    logic              scl_s;

    // Synchroniser chains plus one history flop per line; lines idle high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sda_sync_q <= {STAGES{1'b1}};
            scl_sync_q <= {STAGES{1'b1}};
            sda_prev_q <= 1'b1;
            scl_prev_q <= 1'b1;
        end else begin
            sda_sync_q <= {sda_sync_q[STAGES-2:0], sda_i};
            scl_sync_q <= {scl_sync_q[STAGES-2:0], scl_i};
            sda_prev_q <= sda_sync_q[STAGES-1];
            scl_prev_q <= scl_sync_q[STAGES-1];
        end
    end

    assign sda_s      = sda_sync_q[STAGES-1];
    assign scl_s      = scl_sync_q[STAGES-1];
    assign sda_o      = sda_s;
    assign scl_rise_o = scl_s & ~scl_prev_q;
    assign scl_fall_o = ~scl_s & scl_prev_q;
    // SDa may only move with SCl held high across both samples to count as start/stop.
    assign start_o    = sda_prev_q & ~sda_s & scl_s & scl_prev_q;
    assign stop_o     = ~sda_prev_q & sda_s & scl_s & scl_prev_q;

endmodule

// File: rtl/serial_reg_bridge.sv
// Serial-to-register bridge: decodes a serial frame, issues one bus request, shifts status/read data back.
// Optional SRB_PARITY_EN adds an even-parity bit to the received frame and to the return stream.
module serial_reg_bridge
    import serial_reg_bridge_pkg::*;
#(
    parameter int DATA_W      = DATA_W_DEF,
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int TO_CYC      = TO_CYC_DEF,
    parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                SDa,
    input  logic                SCl,
    output logic                RDa,
    serial_reg_bridge_if.master bus,
    output logic                timeout,
    output logic                busy,
    output logic                frame_err
);

`ifdef SRB_PARITY_EN
    localparam logic PAR_EN = 1'b1;
`else
    localparam logic PAR_EN = 1'b0;
`endif

    localparam int TX_W = 2 + DATA_W + 1;
    localparam int TO_W = $clog2(TO_CYC + 1);

    srb_state_e        state_q;
    logic [CNT_W-1:0]  bit_cnt_q;
    logic [TO_W-1:0]   to_cnt_q;
    logic              par_q;
    logic              rw_q;
    logic              seen_rise_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] data_q;
    logic [TX_W-1:0]   tx_q;
    logic [1:0]        status_q;
    logic              wr_q;
    logic              rd_q;
    logic              rda_q;
    logic              timeout_q;
    logic              busy_q;
    logic              frame_err_q;

    logic              sda_s;
    logic              scl_rise_s;
    logic              scl_fall_s;
    logic              start_s;
    logic              stop_s;
    logic [CNT_W-1:0]  hdr_last_s;
    logic [CNT_W-1:0]  wd_last_s;
    logic [CNT_W-1:0]  tx_last_s;
    logic              frame_end_s;
    logic              resp_s;

    srb_edge_sync #(.STAGES(SYNC_STAGES)) u_edge (
        .clk        (clk),
        .rst_n      (rst_n),
        .sda_i      (SDa),
        .scl_i      (SCl),
        .sda_o      (sda_s),
        .scl_rise_o (scl_rise_s),
        .scl_fall_o (scl_fall_s),
        .start_o    (start_s),
        .stop_o     (stop_s)
    );

    // Return word left-aligned: status, read data (zeroed unless acked), then even parity.
    function automatic logic [TX_W-1:0] build_tx(input logic [1:0] st, input logic rd_op,
                                                 input logic [DATA_W-1:0] rdat);
        logic [DATA_W-1:0] d;
        logic [TX_W-1:0]   t;
        d = (rd_op && (st == ST_ACK)) ? rdat : {DATA_W{1'b0}};
        if (rd_op) begin
            t = {st, d, PAR_EN & (^{st, d})};
        end else begin
            t = {st, PAR_EN & (^st), {DATA_W{1'b0}}};
        end
        return t;
    endfunction

    assign hdr_last_s  = CNT_W'(ADDR_W) + CNT_W'(PAR_EN & rw_q);
    assign wd_last_s   = CNT_W'(DATA_W - 1) + CNT_W'(PAR_EN);
    assign tx_last_s   = rw_q ? (CNT_W'(DATA_W + 1) + CNT_W'(PAR_EN)) : (CNT_W'(1) + CNT_W'(PAR_EN));
    assign frame_end_s = (state_q == S_HDR) ? (bit_cnt_q == hdr_last_s) : (bit_cnt_q == wd_last_s);
    assign resp_s      = bus.ack | bus.nack | bus.unknown;

    // Main sequencer: frame reception, bus request/response and return shifting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            bit_cnt_q   <= '0;
            to_cnt_q    <= '0;
            par_q       <= 1'b0;
            rw_q        <= 1'b0;
            seen_rise_q <= 1'b0;
            addr_q      <= '0;
            data_q      <= '0;
            tx_q        <= '0;
            status_q    <= ST_ACK;
            wr_q        <= 1'b0;
            rd_q        <= 1'b0;
            rda_q       <= 1'b0;
            timeout_q   <= 1'b0;
            busy_q      <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            timeout_q   <= 1'b0;
            frame_err_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start_s) begin
                        state_q   <= S_HDR;
                        bit_cnt_q <= '0;
                        par_q     <= 1'b0;
                        busy_q    <= 1'b1;
                    end
                end
                S_HDR, S_WDATA: begin
                    if (start_s || stop_s) begin
                        frame_err_q <= 1'b1;
                        bit_cnt_q   <= '0;
                        par_q       <= 1'b0;
                        busy_q      <= start_s;
                        state_q     <= start_s ? S_HDR : S_IDLE;
                    end else if (scl_rise_s) begin
                        par_q     <= par_q ^ sda_s;
                        bit_cnt_q <= bit_cnt_q + CNT_W'(1);
                        if (state_q == S_HDR) begin
                            if (bit_cnt_q == '0) begin
                                rw_q <= sda_s;
                            end else if (bit_cnt_q <= CNT_W'(ADDR_W)) begin
                                addr_q <= {addr_q[ADDR_W-2:0], sda_s};
                            end
                        end else if (bit_cnt_q < CNT_W'(DATA_W)) begin
                            data_q <= {data_q[DATA_W-2:0], sda_s};
                        end
                        // Parity runs over the whole frame, so it carries from header into data.
                        if (frame_end_s) begin
                            bit_cnt_q <= '0;
                            if ((state_q == S_HDR) && !rw_q) begin
                                state_q <= S_WDATA;
                            end else if (PAR_EN && (par_q ^ sda_s)) begin
                                frame_err_q <= 1'b1;
                                busy_q      <= 1'b0;
                                state_q     <= S_IDLE;
                            end else begin
                                state_q <= S_REQ;
                            end
                        end
                    end
                end
                S_REQ: begin
                    wr_q     <= ~rw_q;
                    rd_q     <= rw_q;
                    to_cnt_q <= '0;
                    state_q  <= S_WAIT;
                end
                S_WAIT: begin
                    if (resp_s || (to_cnt_q == TO_W'(TO_CYC - 1))) begin
                        wr_q      <= 1'b0;
                        rd_q      <= 1'b0;
                        timeout_q <= ~resp_s;
                        status_q  <= bus.ack ? ST_ACK : bus.nack ? ST_NACK : bus.unknown ? ST_UNK : ST_TO;
                        state_q   <= S_LOAD;
                    end else if (to_cnt_q != TO_W'(TO_CYC)) begin
                        to_cnt_q <= to_cnt_q + TO_W'(1);
                    end
                end
                S_LOAD: begin
                    tx_q        <= build_tx(status_q, rw_q, bus.rdata);
                    rda_q       <= status_q[1];
                    bit_cnt_q   <= '0;
                    seen_rise_q <= 1'b0;
                    state_q     <= S_SHOUT;
                end
                S_SHOUT: begin
                    if (stop_s) begin
                        rda_q   <= 1'b0;
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end else if (start_s) begin
                        rda_q     <= 1'b0;
                        bit_cnt_q <= '0;
                        par_q     <= 1'b0;
                        state_q   <= S_HDR;
                    end else if (scl_rise_s) begin
                        seen_rise_q <= 1'b1;
                    end else if (scl_fall_s && seen_rise_q) begin
                        // Only advance after the master has clocked the current bit in.
                        seen_rise_q <= 1'b0;
                        if (bit_cnt_q == tx_last_s) begin
                            rda_q   <= 1'b0;
                            state_q <= S_DONE;
                        end else begin
                            tx_q      <= {tx_q[TX_W-2:0], 1'b0};
                            rda_q     <= tx_q[TX_W-2];
                            bit_cnt_q <= bit_cnt_q + CNT_W'(1);
                        end
                    end
                end
                S_DONE: begin
                    if (start_s) begin
                        bit_cnt_q <= '0;
                        par_q     <= 1'b0;
                        state_q   <= S_HDR;
                    end else if (stop_s) begin
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    wr_q    <= 1'b0;
                    rd_q    <= 1'b0;
                    rda_q   <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.addr  = addr_q;
    assign bus.data  = data_q;
    assign bus.wr    = wr_q;
    assign bus.rd    = rd_q;
    assign RDa       = rda_q;
    assign timeout   = timeout_q;
    assign busy      = busy_q;
    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_serial_reg_bridge.sv
// Randomised bench for serial_reg_bridge: a bit-banging master, a responding slave and a frame-level model.
`timescale 1ns/1ps
module tb_serial_reg_bridge;

    localparam int DW = 32;
    localparam int AW = 16;
    localparam int TO = 24;
    localparam int HB = 6;
`ifdef SRB_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif
    localparam int K_ACK = 0, K_NACK = 1, K_UNK = 2, K_NONE = 3, K_BOTH = 4;

    logic clk = 1'b0;
    logic rst_n, SDa, SCl, RDa, timeout, busy, frame_err;

    serial_reg_bridge_if #(.DATA_W(DW), .ADDR_W(AW)) bus_if ();

    serial_reg_bridge #(.DATA_W(DW), .ADDR_W(AW), .TO_CYC(TO), .SYNC_STAGES(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .SDa       (SDa),
        .SCl       (SCl),
        .RDa       (RDa),
        .bus       (bus_if),
        .timeout   (timeout),
        .busy      (busy),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    int resp_kind = K_ACK, resp_delay = 1;
    logic [DW-1:0] slave_rdata = '0;
    int wr_win, rd_win, to_pulses, fe_pulses, unstable, req_cycles, last_len;
    logic [AW-1:0] seen_addr;
    logic [DW-1:0] seen_data;
    logic prev_wr = 1'b0, prev_rd = 1'b0;

    assign bus_if.rdata = slave_rdata;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    // Slave responder and bus monitor, sampling at negedge.
    initial begin
        bus_if.ack = 1'b0; bus_if.nack = 1'b0; bus_if.unknown = 1'b0;
        wr_win = 0; rd_win = 0; to_pulses = 0; fe_pulses = 0; unstable = 0; req_cycles = 0; last_len = 0;
        forever begin
            @(negedge clk);
            if (bus_if.wr && !prev_wr) wr_win++;
            if (bus_if.rd && !prev_rd) rd_win++;
            prev_wr = bus_if.wr; prev_rd = bus_if.rd;
            if (timeout)   to_pulses++;
            if (frame_err) fe_pulses++;
            bus_if.ack = 1'b0; bus_if.nack = 1'b0; bus_if.unknown = 1'b0;
            if (bus_if.wr || bus_if.rd) begin
                if (req_cycles == 0) begin
                    seen_addr = bus_if.addr; seen_data = bus_if.data;
                end else if (bus_if.addr != seen_addr || bus_if.data != seen_data) begin
                    unstable++;
                end
                req_cycles++;
                last_len = req_cycles;
                if (req_cycles == resp_delay) begin
                    bus_if.ack     = (resp_kind == K_ACK) || (resp_kind == K_BOTH);
                    bus_if.nack    = (resp_kind == K_NACK) || (resp_kind == K_BOTH);
                    bus_if.unknown = (resp_kind == K_UNK);
                end
            end else begin
                req_cycles = 0;
            end
        end
    end

    function automatic logic [1:0] model_status(input int kind);
        case (kind)
            K_ACK:   return 2'b00;
            K_NACK:  return 2'b01;
            K_UNK:   return 2'b10;
            K_NONE:  return 2'b11;
            K_BOTH:  return 2'b00;
            default: return 2'b00;
        endcase
    endfunction

    task automatic clks(input int n);
        repeat (n) @(posedge clk);
    endtask

    task automatic send_start();
        SCl = 1'b0; clks(HB); SDa = 1'b1; clks(HB); SCl = 1'b1; clks(HB);
        SDa = 1'b0; clks(HB); SCl = 1'b0; clks(HB);
    endtask

    task automatic send_stop();
        SCl = 1'b0; clks(HB); SDa = 1'b0; clks(HB); SCl = 1'b1; clks(HB); SDa = 1'b1; clks(HB);
    endtask

    task automatic send_bit(input bit b);
        SDa = b; clks(HB); SCl = 1'b1; clks(HB); SCl = 1'b0;
    endtask

    task automatic send_frame(input bit is_rd, input logic [AW-1:0] a, input logic [DW-1:0] d, input bit flip);
        bit fr[$];
        bit p;
        fr.push_back(is_rd);
        for (int i = AW - 1; i >= 0; i--) fr.push_back(a[i]);
        if (!is_rd) for (int i = DW - 1; i >= 0; i--) fr.push_back(d[i]);
        if (PAR) begin
            p = 1'b0;
            foreach (fr[i]) p ^= fr[i];
            fr.push_back(p ^ flip);
        end
        foreach (fr[i]) send_bit(fr[i]);
        clks(HB); SDa = 1'b0;
    endtask

    task automatic read_ret(input int n, output logic [63:0] v);
        v = '0;
        for (int i = 0; i < n; i++) begin
            clks(HB); @(negedge clk);
            v = {v[62:0], RDa};
            SCl = 1'b1; clks(HB); SCl = 1'b0;
        end
    endtask

    task automatic clear_mon();
        wr_win = 0; rd_win = 0; to_pulses = 0; fe_pulses = 0; unstable = 0; last_len = 0;
    endtask

    task automatic do_txn(input bit is_rd, input logic [AW-1:0] a, input logic [DW-1:0] d,
                          input int kind, input int dly, input logic [DW-1:0] rdat, input bit flip);
        logic [1:0]  st;
        logic [63:0] exp_v, got_v;
        int nb;
        resp_kind = kind; resp_delay = dly; slave_rdata = rdat;
        clear_mon();
        send_start();
        send_frame(is_rd, a, d, flip);
        clks(TO + 40);
        if (flip && PAR) begin
            check_eq("perr_fe", 64'(fe_pulses), 64'd1);
            check_eq("perr_no_req", 64'(wr_win + rd_win), 64'd0);
            check_eq("perr_busy", 64'(busy), 64'd0);
        end else begin
            st = model_status(kind);
            check_eq("wr_windows", 64'(wr_win), is_rd ? 64'd0 : 64'd1);
            check_eq("rd_windows", 64'(rd_win), is_rd ? 64'd1 : 64'd0);
            check_eq("addr", 64'(seen_addr), 64'(a));
            if (!is_rd) check_eq("data", 64'(seen_data), 64'(d));
            check_eq("stable", 64'(unstable), 64'd0);
            check_eq("req_len", 64'(last_len), (kind == K_NONE) ? 64'(TO) : 64'(dly));
            check_eq("to_pulse", 64'(to_pulses), (kind == K_NONE) ? 64'd1 : 64'd0);
            check_eq("no_fe", 64'(fe_pulses), 64'd0);
            check_eq("busy_hi", 64'(busy), 64'd1);
            exp_v = is_rd ? {30'd0, st, ((st == 2'b00) ? rdat : 32'h0)} : {62'd0, st};
            nb = is_rd ? 2 + DW : 2;
            if (PAR) begin
                exp_v = {exp_v[62:0], ^exp_v};
                nb++;
            end
            read_ret(nb, got_v);
            check_eq("ret", got_v, exp_v);
            clks(HB);
            check_eq("rda_low", 64'(RDa), 64'd0);
        end
        send_stop();
        clks(8);
        check_eq("busy_lo", 64'(busy), 64'd0);
    endtask

    initial begin
        int w;
        rst_n = 1'b0; SDa = 1'b1; SCl = 1'b1;
        clks(4);
        @(negedge clk);
        check_eq("rst_wr", 64'(bus_if.wr), 64'd0);
        check_eq("rst_rd", 64'(bus_if.rd), 64'd0);
        check_eq("rst_busy", 64'(busy), 64'd0);
        check_eq("rst_rda", 64'(RDa), 64'd0);
        check_eq("rst_addr", 64'(bus_if.addr), 64'd0);
        check_eq("rst_data", 64'(bus_if.data), 64'd0);
        check_eq("rst_pulses", 64'({timeout, frame_err}), 64'd0);
        rst_n = 1'b1;
        clks(4);

        do_txn(1'b0, 16'h9004, 32'hDEADBEEF, K_ACK, 3, 32'h0, 1'b0);
        do_txn(1'b1, 16'h9010, 32'h0, K_ACK, 2, 32'h12345678, 1'b0);
        do_txn(1'b1, 16'h9020, 32'h0, K_NONE, 1, 32'hFFFFFFFF, 1'b0);
        do_txn(1'b0, 16'h00FF, 32'h0F0F0F0F, K_NACK, 1, 32'h0, 1'b0);
        do_txn(1'b1, 16'hFFFF, 32'h0, K_UNK, 4, 32'hCAFEF00D, 1'b0);
        do_txn(1'b1, 16'h1234, 32'h0, K_BOTH, 2, 32'hA5A5A5A5, 1'b0);

        // Frame aborted by stop after 10 header bits.
        clear_mon();
        send_start();
        for (int i = 0; i < 10; i++) send_bit(i[0]);
        send_stop();
        clks(10);
        check_eq("abort_fe", 64'(fe_pulses), 64'd1);
        check_eq("abort_no_req", 64'(wr_win + rd_win), 64'd0);
        check_eq("abort_busy", 64'(busy), 64'd0);

`ifdef SRB_PARITY_EN
        do_txn(1'b0, 16'h4242, 32'h13579BDF, K_ACK, 1, 32'h0, 1'b1);
`endif

        // Reset while waiting for a response.
        resp_kind = K_NONE; resp_delay = 1;
        clear_mon();
        send_start();
        send_frame(1'b1, 16'h0BAD, 32'h0, 1'b0);
        w = 0;
        while (!bus_if.rd && w < 100) begin
            @(negedge clk);
            w++;
        end
        check_eq("wait_rd_seen", 64'(bus_if.rd), 64'd1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_eq("rst_wait_rd", 64'(bus_if.rd), 64'd0);
        check_eq("rst_wait_busy", 64'(busy), 64'd0);
        SCl = 1'b1; SDa = 1'b1;
        clks(4);
        @(negedge clk);
        rst_n = 1'b1;
        to_pulses = 0;
        clks(TO + 10);
        check_eq("rst_no_timeout", 64'(to_pulses), 64'd0);
        do_txn(1'b0, 16'h5555, 32'h87654321, K_ACK, 2, 32'h0, 1'b0);

        for (int t = 0; t < 10; t++) begin
            do_txn(1'($urandom_range(0, 1)), 16'($urandom), $urandom, int'($urandom_range(0, 4)),
                   int'($urandom_range(1, 6)), $urandom, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
